// File: rtl/protocol_tx.sv
// Serial frame transmitter for the three-wire lamp link: 16-bit header {command, length} then length payload bytes, MSB first.
// Latency: cs falls and the first header bit appears on mosi one cycle after the start handshake; all outputs are registered.
// Backpressure: payload bytes are pulled one at a time; while no byte is offered the link stalls with cs low and dck low.
module protocol_tx #(
  parameter int CLKS_PER_HALF = 4,
  parameter int CS_GAP        = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [4:0]  i_command,
  input  logic [10:0] i_length,
  output logic        o_start_ready,
  input  logic [7:0]  i_data,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  output logic        o_dck,
  output logic        o_cs,
  output logic        o_mosi,
  output logic        o_busy,
  output logic        o_error
);

  // One phase counter serves dck half-periods and the inter-frame gap, so size it for the longer of the two.
  localparam int MAXC = (CLKS_PER_HALF > CS_GAP) ? CLKS_PER_HALF : CS_GAP;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, FETCH, HOLD, GAP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    bit_cnt_q;
  logic [10:0]   bytes_q;
  logic [15:0]   shift_q;

  logic          dck_q;
  logic          cs_q;
  logic          mosi_q;
  logic          busy_q;
  logic          data_ready_q;
  logic          error_q;
  logic          start_ready_q;

  logic [CW-1:0] cnt_d;
  logic [4:0]    bit_cnt_d;
  logic [10:0]   bytes_d;
  logic [15:0]   shift_d;
  logic          half_end;
  logic          gap_end;

  // Datapath helpers: next counter/shift values and phase-end detection.
  always_comb begin
    cnt_d     = cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q - 5'd1;
    bytes_d   = bytes_q - 11'd1;
    shift_d   = {shift_q[14:0], 1'b0};
    half_end  = (cnt_q == CW'(CLKS_PER_HALF - 1));
    gap_end   = (cnt_q == CW'(CS_GAP - 1));
  end

  // Frame sequencer with registered link and handshake outputs; reset aborts any frame without hold or gap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      bytes_q       <= '0;
      shift_q       <= '0;
      dck_q         <= 1'b0;
      cs_q          <= 1'b1;
      mosi_q        <= 1'b0;
      busy_q        <= 1'b0;
      data_ready_q  <= 1'b0;
      error_q       <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          start_ready_q <= 1'b1;
          busy_q        <= 1'b0;
          cs_q          <= 1'b1;
          dck_q         <= 1'b0;
          data_ready_q  <= 1'b0;
          if (i_start && start_ready_q) begin
            if (i_length != '0) begin
              shift_q       <= {i_command, i_length};
              bytes_q       <= i_length;
              bit_cnt_q     <= 5'd16;
              cnt_q         <= '0;
              mosi_q        <= i_command[4];
              cs_q          <= 1'b0;
              busy_q        <= 1'b1;
              start_ready_q <= 1'b0;
              state_q       <= LOW;
            end else begin
              // A zero-length frame could never be terminated by the receiver.
              error_q <= 1'b1;
            end
          end
        end

        LOW: begin
          if (half_end) begin
            cnt_q   <= '0;
            dck_q   <= 1'b1;
            state_q <= HIGH;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        HIGH: begin
          if (half_end) begin
            cnt_q     <= '0;
            dck_q     <= 1'b0;
            bit_cnt_q <= bit_cnt_d;
            if (bit_cnt_q > 5'd1) begin
              // mosi only moves together with the falling dck edge.
              shift_q <= shift_d;
              mosi_q  <= shift_q[14];
              state_q <= LOW;
            end else if (bytes_q != '0) begin
              data_ready_q <= 1'b1;
              state_q      <= FETCH;
            end else begin
              state_q <= HOLD;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        FETCH: begin
          if (i_data_valid) begin
            shift_q      <= {i_data, 8'h00};
            mosi_q       <= i_data[7];
            bytes_q      <= bytes_d;
            bit_cnt_q    <= 5'd8;
            data_ready_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= LOW;
          end
        end

        HOLD: begin
          if (half_end) begin
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        GAP: begin
          if (gap_end) begin
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_start_ready = start_ready_q;
  assign o_data_ready  = data_ready_q;
  assign o_dck         = dck_q;
  assign o_cs          = cs_q;
  assign o_mosi        = mosi_q;
  assign o_busy        = busy_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_protocol_tx.sv
// Directed bench for protocol_tx: header/payload bit order, cs timing, stalls, zero-length rejection, reset abort, back-to-back frames.
// A passive monitor decodes the link on the falling system clock edge; stimulus changes 1 time unit after it.
// Payload is offered per byte with optional stalls, or held valid continuously.
module tb_protocol_tx;

  localparam int CPH = 2;
  localparam int GAPC = 8;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [4:0]  i_command;
  logic [10:0] i_length;
  logic        o_start_ready;
  logic [7:0]  i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic        o_dck;
  logic        o_cs;
  logic        o_mosi;
  logic        o_busy;
  logic        o_error;

  int checks = 0;
  int failures = 0;

  // monitor state
  int          cyc = 0;
  int          edges = 0;
  int          viol = 0;
  int          cs_low = 0;
  int          cs_rises = 0;
  int          cs_falls = 0;
  int          cs_rise_cyc = 0;
  int          cs_fall_cyc = 0;
  int          sr_rise_cyc = 0;
  int          hs = 0;
  logic [63:0] rx_bits = '0;
  logic        prev_dck = 1'b0;
  logic        prev_mosi = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_sr = 1'b0;

  protocol_tx #(.CLKS_PER_HALF(CPH), .CS_GAP(GAPC)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_command    (i_command),
    .i_length     (i_length),
    .o_start_ready(o_start_ready),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .o_dck        (o_dck),
    .o_cs         (o_cs),
    .o_mosi       (o_mosi),
    .o_busy       (o_busy),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  // Link decoder: capture mosi on rising dck, check mosi stability, track cs and start_ready edges.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_dck === 1'b1 && prev_dck === 1'b0) begin
      edges = edges + 1;
      rx_bits = {rx_bits[62:0], o_mosi};
      if (o_mosi !== prev_mosi) viol = viol + 1;
    end
    if (o_dck === 1'b1 && prev_dck === 1'b1 && o_mosi !== prev_mosi) viol = viol + 1;
    if (o_cs === 1'b0) cs_low = cs_low + 1;
    if (o_cs === 1'b1 && prev_cs === 1'b0) begin cs_rises = cs_rises + 1; cs_rise_cyc = cyc; end
    if (o_cs === 1'b0 && prev_cs === 1'b1) begin cs_falls = cs_falls + 1; cs_fall_cyc = cyc; end
    if (o_start_ready === 1'b1 && prev_sr === 1'b0) sr_rise_cyc = cyc;
    prev_dck = o_dck;
    prev_mosi = o_mosi;
    prev_cs = o_cs;
    prev_sr = o_start_ready;
  end

  // Payload handshake counter.
  always @(posedge clk) begin
    if (i_rst_n === 1'b1 && i_data_valid === 1'b1 && o_data_ready === 1'b1) hs = hs + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [4:0] cmd, input logic [10:0] len);
    i_command = cmd;
    i_length = len;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_start_ready === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall, output bit ok, output bit bad);
    ok = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (o_data_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (ok) begin
      for (int i = 0; i < stall; i++) begin
        tick();
        if (o_cs !== 1'b0 || o_dck !== 1'b0 || o_data_ready !== 1'b1) bad = 1'b1;
      end
      i_data = b;
      i_data_valid = 1'b1;
      @(posedge clk);
      #1;
      i_data_valid = 1'b0;
    end
  endtask

  initial begin
    int e0, c0, h0, r0, f1, n;
    bit ok, ok2, bad, anybad;
    logic [4:0]  rc;
    logic [10:0] rl;
    logic [7:0]  rb;
    logic [63:0] exp, mask;

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_command = '0;
    i_length = '0;
    i_data = '0;
    i_data_valid = 1'b0;
    repeat (3) tick();

    // Reset state: {cs,dck,mosi,busy,data_ready,error,start_ready}
    chk("reset_outputs", {o_cs, o_dck, o_mosi, o_busy, o_data_ready, o_error, o_start_ready}, 7'b1000001);
    i_rst_n = 1'b1;
    repeat (2) tick();

    // Frame 1: cmd 0, len 1, byte A5 offered before start.
    i_data = 8'hA5;
    i_data_valid = 1'b1;
    e0 = edges; c0 = cs_low; h0 = hs;
    start_frame(5'd0, 11'd1);
    chk("f1_busy", {o_cs, o_busy, o_start_ready, o_mosi}, 4'b0100);
    wait_idle(1000, ok);
    chk("f1_done", ok, 1);
    tick();
    chk("f1_edges", edges - e0, 24);
    chk("f1_bits", rx_bits[23:0], {5'd0, 11'd1, 8'hA5});
    chk("f1_cs_low", cs_low - c0, 99);
    chk("f1_sr_after_gap", sr_rise_cyc - cs_rise_cyc, GAPC);
    chk("f1_handshakes", hs - h0, 1);
    i_data_valid = 1'b0;

    // Frame 2: len 3, bytes 01,80,FF with a 10-cycle stall before the second byte.
    e0 = edges; h0 = hs; anybad = 1'b0;
    start_frame(5'h03, 11'd3);
    send_byte(8'h01, 0, ok, bad);  anybad = anybad | bad | !ok;
    send_byte(8'h80, 10, ok, bad); anybad = anybad | bad | !ok;
    send_byte(8'hFF, 0, ok, bad);  anybad = anybad | bad | !ok;
    chk("f2_stall_link_quiet", anybad, 0);
    wait_idle(1000, ok);
    chk("f2_done", ok, 1);
    chk("f2_edges", edges - e0, 40);
    chk("f2_bits", rx_bits[39:0], {5'h03, 11'd3, 8'h01, 8'h80, 8'hFF});
    chk("f2_handshakes", hs - h0, 3);

    // Zero-length start is rejected with a single error pulse.
    e0 = edges;
    start_frame(5'h05, 11'd0);
    chk("zl_error_pulse", {o_error, o_cs, o_start_ready}, 3'b111);
    tick();
    chk("zl_error_clear", {o_error, o_cs, o_start_ready, o_busy}, 4'b0110);
    chk("zl_no_edges", edges - e0, 0);

    // Reset in the middle of the 5th payload bit.
    i_data = 8'h5A;
    i_data_valid = 1'b1;
    e0 = edges;
    start_frame(5'h02, 11'd2);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (edges - e0 >= 20) begin ok = 1'b1; break; end
      tick();
    end
    chk("rst_reach_bit5", ok, 1);
    repeat (CPH) tick();
    chk("rst_mid_frame_busy", {o_cs, o_busy}, 2'b01);
    i_rst_n = 1'b0;
    tick();
    chk("rst_abort", {o_cs, o_dck, o_busy, o_start_ready, o_data_ready}, 5'b10010);
    i_rst_n = 1'b1;
    tick();
    i_data = 8'h3C;
    e0 = edges;
    start_frame(5'h0A, 11'd1);
    wait_idle(1000, ok);
    chk("rst_fresh_done", ok, 1);
    chk("rst_fresh_edges", edges - e0, 24);
    chk("rst_fresh_bits", rx_bits[23:0], {5'h0A, 11'd1, 8'h3C});

    // Back-to-back with start held high.
    i_data = 8'hC3;
    i_data_valid = 1'b1;
    r0 = cs_rises;
    i_command = 5'h1F;
    i_length = 11'd2;
    i_start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (cs_rises > r0) begin ok = 1'b1; break; end
    end
    f1 = cs_falls;
    ok2 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (cs_falls > f1) begin ok2 = 1'b1; break; end
    end
    i_start = 1'b0;
    chk("b2b_both_frames", {ok, ok2}, 2'b11);
    chk("b2b_gap_respected", (cs_fall_cyc - cs_rise_cyc) >= GAPC, 1);
    e0 = edges;
    wait_idle(1000, ok);
    chk("b2b_second_done", ok, 1);
    chk("b2b_second_bits", rx_bits[31:0], {5'h1F, 11'd2, 8'hC3, 8'hC3});
    i_data_valid = 1'b0;

    // Random frame with random stalls; mosi stability is checked throughout the run.
    rc = 5'($urandom_range(0, 31));
    rl = 11'($urandom_range(1, 4));
    exp = {48'd0, rc, rl};
    e0 = edges;
    anybad = 1'b0;
    start_frame(rc, rl);
    for (int i = 0; i < int'(rl); i++) begin
      rb = 8'($urandom_range(0, 255));
      exp = {exp[55:0], rb};
      send_byte(rb, $urandom_range(0, 3), ok, bad);
      anybad = anybad | bad | !ok;
    end
    wait_idle(1000, ok);
    n = 16 + 8 * int'(rl);
    mask = (64'd1 << n) - 64'd1;
    chk("rnd_done", {ok, anybad}, 2'b10);
    chk("rnd_edges", edges - e0, n);
    chk("rnd_bits", rx_bits & mask, exp);
    chk("mosi_stable", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/protocol_tx.md
Name: protocol_tx

Overview:
Serial frame transmitter; drives the three-wire lamp link (dck, active-low cs, mosi) from the host side toward the FPGA frame receiver. It accepts a frame header (5-bit command, 11-bit byte length) through a start handshake. It then pulls exactly `length` payload bytes from a valid/ready byte stream and serialises them MSB first. The block does not interpret the payload. For command 0 (keyframe), the upstream source supplies the 6-bit type, the 10-bit duration and the data inside the payload bytes.

Parameters:
CLKS_PER_HALF, 4, i_clk cycles per dck half-period; legal values are ≥2, because the receiver oversamples dck with its own clock.
CS_GAP, 8, i_clk cycles cs is held high after a frame before the next frame may start; legal values are ≥1.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_start  in  1  start request, qualified by o_start_ready
i_command  in  5  frame command, sampled on start handshake
i_length  in  11  payload byte count, sampled on start handshake
o_start_ready  out  1  idle and able to accept a frame
i_data  in  8  payload byte
i_data_valid  in  1  payload byte valid
o_data_ready  out  1  payload byte accepted when high with i_data_valid
o_dck  out  1  serial clock; idle level is low
o_cs  out  1  chip select, active low
o_mosi  out  1  serial data
o_busy  out  1  frame in progress (cs low or gap running)
o_error  out  1  one-cycle pulse when a start request with length 0 is rejected

Behaviour:
- All outputs are registered.
- Reset (i_rst_n=0 at a clock edge):
  - next cycle: o_cs=1, o_dck=0, o_mosi=0, o_busy=0, o_data_ready=0, o_error=0, o_start_ready=1, state IDLE;
  - reset mid-frame aborts immediately: cs rises, and no hold or gap is applied.
- States: IDLE, LOW, HIGH, FETCH, HOLD, GAP.
- IDLE:
  - o_start_ready=1;
  - on i_start&&o_start_ready with i_length!=0: latch command and length, load shift register = {command, length}, bit counter = 16, go to LOW; o_cs=0, o_busy=1 and o_mosi = command[4] all appear in the next cycle;
  - on i_start with i_length==0: no frame is sent, o_error=1 for one cycle, stay in IDLE. The receiver cannot terminate a zero-length frame.
- LOW:
  - dck=0 for CLKS_PER_HALF cycles, mosi = current bit;
  - then go to HIGH.
- HIGH:
  - dck=1 for CLKS_PER_HALF cycles; the receiver samples on the rising edge; mosi is unchanged;
  - at the end: decrement bit counter;
  - if bits remain in the shift register: shift left, go to LOW (mosi changes only while dck is low);
  - else if payload bytes remain: go to FETCH;
  - else go to HOLD.
- FETCH:
  - dck=0, o_data_ready=1;
  - on i_data_valid: load i_data, decrement remaining-byte count (11-bit), bit counter = 8, o_data_ready drops, go to LOW;
  - stalls indefinitely with cs low and dck low if no data arrives. The receiver is edge-driven, so a stall is legal.
  - Minimum FETCH duration is 1 cycle, so each byte's first low phase lasts CLKS_PER_HALF+1 cycles or more.
- HOLD:
  - dck=0 for CLKS_PER_HALF cycles;
  - then o_cs=1, go to GAP.
- GAP:
  - cs=1, o_busy=1 for CS_GAP cycles;
  - then o_start_ready=1, go to IDLE.
- Bit order:
  - header: command[4..0], then length[10..0];
  - each payload byte: bit 7 first.
- Total rising dck edges per frame = 16 + 8*length. Exactly length bytes are handshaked; no byte is requested after the last one.
- o_data_ready is never high outside FETCH. o_start_ready is never high while o_busy=1.
- i_start is ignored while busy; i_data_valid is ignored outside FETCH.
- Length 2047 is legal. Counters must not wrap before the final byte.

Test Plan:
- CLKS_PER_HALF=2, CS_GAP=8, start cmd=0 len=1, byte 0xA5 valid already high:
  - mosi sampled on rising edges = 00000 00000000001 10100101 (24 edges);
  - cs low for exactly 99 cycles (24*4 + 1 fetch + 2 hold);
  - o_start_ready high 8 cycles after cs rises.
- Length 3, bytes 0x01,0x80,0xFF; hold i_data_valid low for 10 cycles before byte 2:
  - dck stays low and cs stays low throughout the stall;
  - 40 rising edges in total; bytes are received intact;
  - exactly 3 data handshakes occur.
- i_start with i_length=0: o_error pulses one cycle; cs stays high; o_start_ready stays high.
- Assert i_rst_n=0 during the 5th payload bit of a frame: next cycle cs=1, dck=0, busy=0, start_ready=1; a fresh frame then sends correctly.
- Back-to-back: i_start held high continuously with cmd=0x1F, len=2:
  - the second frame's cs falls no earlier than CS_GAP cycles after the first frame's cs rises;
  - the header of the second frame reads 11111 00000000010.
- mosi stability check over a random frame: mosi never changes while dck=1, and never changes in the same cycle as a rising dck edge.
